apb_rr_master: RTL and testbench
================================

APB_RR_MASTER -- requirements
Module: apb_rr_master

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- NREQ, 2, number of requesters (2..4).
- ADDR_W, 8, APB address width.
- DATA_W, 32, APB data width.
- TIMEOUT, 16, ACCESS cycles allowed without PREADY before abort (>=2).

REQ-002 Ports SHALL be (name, direction, width, meaning):
- PCLK, in, 1, the one clock.
- PRESETn, in, 1, asynchronous active-low reset.
- req_valid, in, NREQ, per-requester command valid.
- req_ready, out, NREQ, per-requester command accepted (one-hot or zero).
- req_write, in, NREQ, per-requester 1=write, 0=read.
- req_addr, in, NREQ*ADDR_W, packed addresses, requester i at [i*ADDR_W +: ADDR_W].
- req_wdata, in, NREQ*DATA_W, packed write data.
- rsp_valid, out, NREQ, one-cycle completion pulse to the owning requester.
- rsp_rdata, out, DATA_W, read data qualified by rsp_valid.
- rsp_err, out, 1, PSLVERR or timeout, qualified by rsp_valid.
- PSEL, PENABLE, PWRITE, out, 1 each, APB control.
- PADDR, out, ADDR_W, APB address.
- PWDATA, out, DATA_W, APB write data.
- PRDATA, in, DATA_W, APB read data.
- PREADY, PSLVERR, in, 1 each, APB completer response.

Function
REQ-003 The FSM SHALL have states IDLE, SETUP and ACCESS.
REQ-004 In IDLE, req_ready SHALL be combinationally one-hot on the round-robin winner among asserted req_valid; a command is accepted on the PCLK edge where req_valid[i] and req_ready[i] are both high.
REQ-005 On acceptance, the block SHALL latch the winner's write, addr, wdata and index, move to SETUP, and set the round-robin pointer to winner+1 mod NREQ.
REQ-006 Round-robin search SHALL start at the pointer; requester 0 has first priority after reset.
REQ-007 In SETUP, PSEL SHALL be 1 and PENABLE 0, with PADDR, PWRITE and PWDATA driven from the latched command; the next state SHALL be ACCESS unconditionally.
REQ-008 In ACCESS, PSEL and PENABLE SHALL both be 1 and all address/control/data outputs SHALL hold stable.
REQ-009 ACCESS SHALL persist while PREADY=0; on the edge with PREADY=1 the FSM SHALL return to IDLE.
REQ-010 The completion edge SHALL register rsp_valid[index]=1 for exactly one cycle, with rsp_rdata=PRDATA for reads (0 for writes) and rsp_err=PSLVERR.
REQ-011 A wait counter SHALL count ACCESS cycles.
REQ-012 If the wait counter reaches TIMEOUT with PREADY still 0, the FSM SHALL return to IDLE and pulse rsp_valid with rsp_err=1 and rsp_rdata=0.
REQ-013 req_ready SHALL be 0 in SETUP and ACCESS; there is no command queue.
REQ-014 Minimum spacing between acceptances SHALL be 3 cycles (IDLE, SETUP, ACCESS).
REQ-015 In IDLE, PSEL, PENABLE and PWRITE SHALL be 0; PADDR and PWDATA SHALL hold their last values.
REQ-016 If req_valid drops after acceptance, the transfer SHALL still complete normally.
REQ-017 A requester SHALL be allowed to reassert req_valid in the same cycle it receives rsp_valid; it then competes in IDLE on the next cycle.

Reset
REQ-018 PRESETn low SHALL asynchronously force state=IDLE, pointer=0, wait counter=0, and the outputs PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata and rsp_err to 0.
REQ-019 Reset asserted mid-transfer SHALL abort the transfer with no rsp_valid pulse.
REQ-020 The first acceptance SHALL be possible on the first PCLK edge after PRESETn deasserts.

Structure
REQ-021 A shared package apb_pkg SHALL hold the APB_ADDR_W and APB_DATA_W constants and the state enum apb_state_e {IDLE, SETUP, ACCESS}.
REQ-022 Arbitration SHALL be a sub-module rr_arbiter (NREQ requests, pointer in, one-hot grant out); the FSM, latches and timeout counter stay in apb_rr_master.

Verification
REQ-023 Single write: req0 write, addr 0x10, data 0xDEADBEEF, completer with PREADY=1 -> SETUP then ACCESS, PADDR=0x10, PWDATA=0xDEADBEEF; rsp_valid[0] 2 cycles after acceptance with rsp_err=0.
REQ-024 Read with wait states: req1 read addr 0x24, PREADY held low 3 cycles, PRDATA=0x12345678 -> ACCESS lasts 4 cycles with signals stable; rsp_valid[1], rsp_rdata=0x12345678.
REQ-025 Contention: req0 and req1 both valid continuously from reset -> grants alternate 0,1,0,1; acceptances spaced exactly 3 cycles when PREADY=1.
REQ-026 Error: PSLVERR=1 together with PREADY on a write to 0x30 -> rsp_err=1 pulsed with rsp_valid.
REQ-027 Timeout: PREADY stuck at 0 with TIMEOUT=16 -> after 16 ACCESS cycles, PSEL=0, rsp_valid with rsp_err=1 and rsp_rdata=0.
REQ-028 Reset mid-ACCESS: PRESETn low for 1 cycle -> PSEL and PENABLE 0 immediately, no rsp_valid; the next acceptance goes to requester 0.

Source files
------------

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB widths and transfer-phase encoding
package apb_pkg;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot grant starting the search at a pointer
module rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [NREQ-1:0]  o_gnt,
  output logic [PTR_W-1:0] o_idx
);

  logic [PTR_W-1:0] w_cand;
  logic             w_found;

  // Walk the requesters from the pointer upward (wrapping) and grant the first one asserted
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = PTR_W'((int'(i_ptr) + k) % NREQ);
      if (!w_found && i_req[w_cand]) begin
        o_gnt[w_cand] = 1'b1;
        o_idx         = w_cand;
        w_found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_rr_master.sv
// rtl/apb_rr_master.sv - APB requester that serves NREQ clients round-robin with a wait timeout
module apb_rr_master
  import apb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic                     PCLK,
  input  logic                     PRESETn,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ-1:0]          req_write,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_err,
  output logic                     PSEL,
  output logic                     PENABLE,
  output logic                     PWRITE,
  output logic [ADDR_W-1:0]        PADDR,
  output logic [DATA_W-1:0]        PWDATA,
  input  logic [DATA_W-1:0]        PRDATA,
  input  logic                     PREADY,
  input  logic                     PSLVERR
);

  localparam int PTR_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

  apb_state_e        r_state;
  apb_state_e        w_next;
  logic [PTR_W-1:0]  r_ptr;
  logic [PTR_W-1:0]  r_idx;
  logic [PTR_W-1:0]  w_win_idx;
  logic [NREQ-1:0]   w_gnt;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [CNT_W-1:0]  r_wait;
  logic              w_accept;
  logic              w_done;
  logic              w_timeout;
  logic [NREQ-1:0]   r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;

  rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_win_idx)
  );

  // Phase register; reset drops any transfer in flight without a response
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Next phase, grant exposure and APB control decoded from the current phase
  always_comb begin
    w_next    = r_state;
    req_ready = '0;
    w_accept  = 1'b0;
    w_timeout = 1'b0;
    w_done    = 1'b0;
    PSEL      = 1'b0;
    PENABLE   = 1'b0;
    PWRITE    = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = w_gnt;
        w_accept  = |req_valid;
        if (w_accept) w_next = SETUP;
      end
      SETUP: begin
        PSEL   = 1'b1;
        PWRITE = r_write;
        w_next = ACCESS;
      end
      ACCESS: begin
        PSEL      = 1'b1;
        PENABLE   = 1'b1;
        PWRITE    = r_write;
        w_timeout = !PREADY && (r_wait == LAST_WAIT);
        w_done    = PREADY || w_timeout;
        if (w_done) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Command latch, rotating pointer, wait counter and the one-cycle completion pulse
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_ptr       <= '0;
      r_idx       <= '0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wait      <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_write <= req_write[w_win_idx];
        r_addr  <= req_addr[int'(w_win_idx)*ADDR_W +: ADDR_W];
        r_wdata <= req_wdata[int'(w_win_idx)*DATA_W +: DATA_W];
        r_idx   <= w_win_idx;
        r_ptr   <= PTR_W'((int'(w_win_idx) + 1) % NREQ);
      end
      r_wait      <= (r_state == ACCESS && !w_done) ? r_wait + CNT_W'(1) : '0;
      r_rsp_valid <= '0;
      if (w_done) begin
        r_rsp_valid[r_idx] <= 1'b1;
        r_rsp_err          <= w_timeout || PSLVERR;
        r_rsp_rdata        <= (PREADY && !r_write) ? PRDATA : '0;
      end
    end
  end

  assign PADDR     = r_addr;
  assign PWDATA    = r_wdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_rr_master.sv
// tb/tb_apb_rr_master.sv - self-checking bench for apb_rr_master
module tb_apb_rr_master;

  localparam int NREQ = 2;
  localparam int AW   = 8;
  localparam int DW   = 32;
  localparam int TO   = 16;

  logic                PCLK;
  logic                PRESETn;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ-1:0]     req_write;
  logic [NREQ*AW-1:0]  req_addr;
  logic [NREQ*DW-1:0]  req_wdata;
  logic [NREQ-1:0]     rsp_valid;
  logic [DW-1:0]       rsp_rdata;
  logic                rsp_err;
  logic                PSEL;
  logic                PENABLE;
  logic                PWRITE;
  logic [AW-1:0]       PADDR;
  logic [DW-1:0]       PWDATA;
  logic [DW-1:0]       PRDATA;
  logic                PREADY;
  logic                PSLVERR;

  apb_rr_master #(
    .NREQ    (NREQ),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  typedef struct {
    int          idx;
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          wt;
    logic [31:0] prdata;
    bit          slverr;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          acc;
  } vec_t;

  vec_t            cfg [NREQ];
  vec_t            cur;
  vec_t            exp_q [$];
  vec_t            tbl [6];
  bit              keep [NREQ];
  logic [NREQ-1:0] drop_mask;
  int              gnt_log [$];
  int              acc_log [$];
  int              m_state;
  int              m_ptr;
  int              acc_cnt;
  bit              m_rsp_due;
  int              cyc;
  int              n_chk;
  int              n_pass;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic issue(input vec_t v);
    cfg[v.idx]                  = v;
    req_valid[v.idx]            = 1'b1;
    req_write[v.idx]            = v.wr;
    req_addr[v.idx*AW +: AW]    = v.addr;
    req_wdata[v.idx*DW +: DW]   = v.wdata;
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_state   = 0;
    m_ptr     = 0;
    m_rsp_due = 1'b0;
    acc_cnt   = 0;
    cur       = '{default: 0};
    drop_mask = '0;
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;
    PRDATA    = '0;
  endtask

  // One clock: predict the coming edge, then check the DUT at the following falling edge
  task automatic step();
    int              w;
    int              m_next;
    logic [NREQ-1:0] exp_gnt;
    vec_t            e;
    #1;
    w       = -1;
    exp_gnt = '0;
    m_next  = m_state;
    case (m_state)
      0: begin
        for (int k = 0; k < NREQ; k++) begin
          int c;
          c = (m_ptr + k) % NREQ;
          if (w < 0 && req_valid[c]) w = c;
        end
        if (w >= 0) exp_gnt[w] = 1'b1;
        check("req_ready_idle", 64'(req_ready), 64'(exp_gnt));
        if (w >= 0) begin
          cur     = cfg[w];
          cur.acc = cyc + 1;
          exp_q.push_back(cur);
          gnt_log.push_back(w);
          acc_log.push_back(cur.acc);
          m_ptr   = (w + 1) % NREQ;
          if (!keep[w]) drop_mask[w] = 1'b1;
          acc_cnt = 0;
          m_next  = 1;
        end
      end
      1: begin
        check("req_ready_setup", 64'(req_ready), 64'(0));
        m_next = 2;
      end
      default: begin
        check("req_ready_access", 64'(req_ready), 64'(0));
        if (PREADY || acc_cnt == TO - 1) begin
          m_next    = 0;
          m_rsp_due = 1'b1;
        end else begin
          acc_cnt++;
        end
      end
    endcase
    @(negedge PCLK);
    cyc++;
    m_state = m_next;
    check("psel", 64'(PSEL), 64'(m_state != 0));
    check("penable", 64'(PENABLE), 64'(m_state == 2));
    check("pwrite", 64'(PWRITE), 64'(m_state != 0 && cur.wr));
    check("paddr", 64'(PADDR), 64'(cur.addr));
    check("pwdata", 64'(PWDATA), 64'(cur.wdata));
    if (m_rsp_due) begin
      m_rsp_due = 1'b0;
      if (exp_q.size() == 0) begin
        check("scoreboard_nonempty", 64'(0), 64'(1));
      end else begin
        e = exp_q.pop_front();
        check("rsp_valid", 64'(rsp_valid), 64'(1) << e.idx);
        check("rsp_rdata", 64'(rsp_rdata), 64'(e.exp_rdata));
        check("rsp_err", 64'(rsp_err), 64'(e.exp_err));
        check("rsp_latency", 64'(cyc - e.acc), 64'(2 + ((e.wt >= TO) ? TO - 1 : e.wt)));
      end
    end else begin
      check("rsp_valid_quiet", 64'(rsp_valid), 64'(0));
    end
    for (int k = 0; k < NREQ; k++) if (drop_mask[k]) req_valid[k] = 1'b0;
    drop_mask = '0;
    if (m_state == 2) begin
      PREADY  = (acc_cnt >= cur.wt);
      PRDATA  = cur.prdata;
      PSLVERR = PREADY && cur.slverr;
    end else begin
      PREADY  = 1'b0;
      PRDATA  = 32'h5A5A_A5A5;
      PSLVERR = 1'b0;
    end
  endtask

  task automatic run_until_idle(input string nm, input int budget);
    int n;
    n = 0;
    while (!(m_state == 0 && exp_q.size() == 0 && req_valid == '0) && n < budget) begin
      step();
      n++;
    end
    check({"drain_", nm}, 64'(n < budget), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c0;
    int n;
    int sz;
    vec_t v;
    n_chk = 0;
    n_pass = 0;
    cyc = 0;
    gnt_log.delete();
    acc_log.delete();
    for (int k = 0; k < NREQ; k++) begin
      keep[k] = 1'b0;
      cfg[k]  = '{default: 0};
    end
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    PRESETn   = 1'b0;
    model_reset();

    //             idx wr addr   wdata          wt   prdata         err  exp_rdata      exp_err acc
    tbl[0] = '{0, 1, 8'h10, 32'hDEADBEEF, 0,   32'h0000_0000, 0, 32'h0000_0000, 0, 0};
    tbl[1] = '{1, 0, 8'h24, 32'h0000_0000, 3,   32'h12345678, 0, 32'h12345678, 0, 0};
    tbl[2] = '{0, 1, 8'h30, 32'h0BAD_F00D, 0,   32'hFFFF_FFFF, 1, 32'h0000_0000, 1, 0};
    tbl[3] = '{1, 0, 8'h50, 32'h0000_0000, 1,   32'hCAFEF00D, 1, 32'hCAFEF00D, 1, 0};
    tbl[4] = '{0, 0, 8'h64, 32'h0000_0000, 255, 32'hAAAA_5555, 0, 32'h0000_0000, 1, 0};
    tbl[5] = '{1, 1, 8'h7C, 32'h1357_9BDF, 2,   32'hFFFF_FFFF, 0, 32'h0000_0000, 0, 0};

    repeat (2) @(negedge PCLK);
    check("rst_psel", 64'(PSEL), 64'(0));
    check("rst_penable", 64'(PENABLE), 64'(0));
    check("rst_pwrite", 64'(PWRITE), 64'(0));
    check("rst_paddr", 64'(PADDR), 64'(0));
    check("rst_pwdata", 64'(PWDATA), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
    check("rst_rsp_err", 64'(rsp_err), 64'(0));

    // Contention straight out of reset: both requesters held valid
    PRESETn = 1'b1;
    c0 = cyc;
    keep[0] = 1'b1;
    keep[1] = 1'b1;
    issue('{0, 1, 8'h40, 32'h1111_1111, 0, 32'h0, 0, 32'h0, 0, 0});
    issue('{1, 0, 8'h44, 32'h0, 0, 32'h2222_2222, 0, 32'h2222_2222, 0, 0});
    n = 0;
    while (gnt_log.size() < 4 && n < 40) begin
      step();
      n++;
    end
    check("contention_bound", 64'(gnt_log.size() >= 4), 64'(1));
    keep[0] = 1'b0;
    keep[1] = 1'b0;
    req_valid = '0;
    run_until_idle("contention", 40);
    if (gnt_log.size() >= 4) begin
      check("first_accept_edge", 64'(acc_log[0]), 64'(c0 + 1));
      for (int i = 0; i < 4; i++) check("grant_order", 64'(gnt_log[i]), 64'(i % 2));
      for (int i = 0; i < 3; i++) check("accept_spacing", 64'(acc_log[i+1] - acc_log[i]), 64'(3));
    end

    // Table of single transfers: write, waited read, slave error, timeout, write ignoring PRDATA
    for (int i = 0; i < 6; i++) begin
      issue(tbl[i]);
      run_until_idle($sformatf("vec%0d", i), 60);
    end

    // Reset while a stalled transfer sits in ACCESS
    issue('{1, 0, 8'h88, 32'h0, 255, 32'h7777_7777, 0, 32'h0, 1, 0});
    n = 0;
    while (m_state != 2 && n < 20) begin
      step();
      n++;
    end
    step();
    step();
    check("stall_in_access", 64'(m_state), 64'(2));
    PRESETn = 1'b0;
    #1;
    check("rst_mid_psel", 64'(PSEL), 64'(0));
    check("rst_mid_penable", 64'(PENABLE), 64'(0));
    model_reset();
    req_valid = '0;
    @(negedge PCLK);
    cyc++;
    check("rst_mid_no_rsp", 64'(rsp_valid), 64'(0));
    PRESETn = 1'b1;
    sz = gnt_log.size();
    issue('{1, 1, 8'h9A, 32'hA5A5_0001, 0, 32'h0, 0, 32'h0, 0, 0});
    issue('{0, 0, 8'h9C, 32'h0, 1, 32'h0F0F_0F0F, 0, 32'h0F0F_0F0F, 0, 0});
    run_until_idle("post_reset", 40);
    if (gnt_log.size() >= sz + 2) begin
      check("post_reset_first_grant", 64'(gnt_log[sz]), 64'(0));
      check("post_reset_second_grant", 64'(gnt_log[sz+1]), 64'(1));
    end else begin
      check("post_reset_grants", 64'(gnt_log.size()), 64'(sz + 2));
    end

    step();
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
